// File: rtl/calc_ctrl.sv
// Button-driven calculator: debounced up/down/enter/clear, latched result, 4-digit hex scan.
// Define CALC_MUL_EN to compile in the multiplier (op code 7); otherwise codes are 0..6.
module calc_ctrl #(
    parameter int unsigned W         = 4,
    parameter int unsigned DB_CYCLES = 1000000,
    parameter int unsigned REFRESH   = 100000
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    input  logic           up,
    input  logic           down,
    input  logic           enter,
    input  logic           clear,
    output logic [2:0]     op_code,
    output logic [2*W-1:0] result,
    output logic           valid,
    output logic [3:0]     an,
    output logic [7:0]     seg
);

    localparam int unsigned RW  = 2 * W;
    localparam int unsigned CW  = $clog2(DB_CYCLES + 1);
    localparam int unsigned RCW = $clog2(REFRESH + 1);
`ifdef CALC_MUL_EN
    localparam logic [2:0] OpMax = 3'd7;
`else
    localparam logic [2:0] OpMax = 3'd6;
`endif

    // ------------------------------------------------------------------
    // Button conditioning, bit order {clear, enter, down, up}
    // ------------------------------------------------------------------
    logic [3:0]    btn_raw;
    logic [3:0]    sync1_q, sync2_q;
    logic [1:0]    vld_q;
    logic [3:0]    level_q, level_d;
    logic [3:0]    armed_q, armed_d;
    logic [3:0]    qual;
    logic [3:0]    pulse;
    logic [CW-1:0] cnt_q [4];
    logic [CW-1:0] cnt_d [4];

    assign btn_raw = {clear, enter, down, up};

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            vld_q   <= '0;
            level_q <= '0;
            armed_q <= '0;
            for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
            vld_q   <= {vld_q[0], 1'b1};
            level_q <= level_d;
            armed_q <= armed_d;
            for (int i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    // Until a button has been seen stably released after reset it stays disarmed,
    // so a button held through reset cannot fire.
    always_comb begin
        level_d = level_q;
        armed_d = armed_q;
        qual    = '0;
        pulse   = '0;
        for (int i = 0; i < 4; i++) begin
            cnt_d[i] = cnt_q[i];
            qual[i]  = armed_q[i] ? (sync2_q[i] != level_q[i]) : (vld_q[1] && !sync2_q[i]);
            if (!qual[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CW'(DB_CYCLES - 1)) begin
                cnt_d[i] = '0;
                if (armed_q[i]) begin
                    level_d[i] = sync2_q[i];
                    pulse[i]   = sync2_q[i];
                end else begin
                    armed_d[i] = 1'b1;
                end
            end else begin
                cnt_d[i] = cnt_q[i] + CW'(1);
            end
        end
    end

    logic up_p, down_p, enter_p, clear_p;
    assign up_p    = pulse[0];
    assign down_p  = pulse[1];
    assign enter_p = pulse[2];
    assign clear_p = pulse[3];

    // ------------------------------------------------------------------
    // ALU and control registers
    // ------------------------------------------------------------------
    logic [2:0]    op_q, op_d;
    logic [RW-1:0] res_q, res_d;
    logic          valid_q, valid_d;
    logic [RW-1:0] a_ext, b_ext, calc;

    always_comb begin
        a_ext = RW'(a);
        b_ext = RW'(b);
        calc  = '0;
        case (op_q)
            3'd0: calc = a_ext + b_ext;
            3'd1: calc = a_ext - b_ext;
            3'd2: calc = a_ext & b_ext;
            3'd3: calc = a_ext | b_ext;
            3'd4: calc = a_ext ^ b_ext;
            3'd5: calc = (32'(b) >= RW) ? '0 : (a_ext << b);
            3'd6: calc = (32'(b) >= RW) ? '0 : (a_ext >> b);
`ifdef CALC_MUL_EN
            3'd7: calc = a_ext * b_ext;
`endif
            default: calc = '0;
        endcase
    end

    always_comb begin
        op_d    = op_q;
        res_d   = res_q;
        valid_d = valid_q;
        if (clear_p) begin
            op_d    = '0;
            res_d   = '0;
            valid_d = 1'b0;
        end else begin
            if (enter_p) begin
                res_d   = calc;
                valid_d = 1'b1;
            end
            if (up_p && !down_p) begin
                op_d = (op_q == OpMax) ? 3'd0 : op_q + 3'd1;
            end else if (down_p && !up_p) begin
                op_d = (op_q == 3'd0) ? OpMax : op_q - 3'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q    <= '0;
            res_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            op_q    <= op_d;
            res_q   <= res_d;
            valid_q <= valid_d;
        end
    end

    // ------------------------------------------------------------------
    // Display scan
    // ------------------------------------------------------------------
    logic [RCW-1:0] ref_cnt_q;
    logic [1:0]     digit_q;
    logic [15:0]    res16;
    logic [3:0]     nib;
    logic [6:0]     pat;
    logic [3:0]     an_q, an_d;
    logic [7:0]     seg_q, seg_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            ref_cnt_q <= '0;
            digit_q   <= '0;
        end else if (ref_cnt_q == RCW'(REFRESH - 1)) begin
            ref_cnt_q <= '0;
            digit_q   <= digit_q + 2'd1;
        end else begin
            ref_cnt_q <= ref_cnt_q + RCW'(1);
        end
    end

    assign res16 = 16'(res_q);
    assign nib   = res16[4*digit_q +: 4];

    // Active-high gfedcba pattern, inverted at the output
    always_comb begin
        pat = 7'h00;
        case (nib)
            4'h0: pat = 7'h3F;
            4'h1: pat = 7'h06;
            4'h2: pat = 7'h5B;
            4'h3: pat = 7'h4F;
            4'h4: pat = 7'h66;
            4'h5: pat = 7'h6D;
            4'h6: pat = 7'h7D;
            4'h7: pat = 7'h07;
            4'h8: pat = 7'h7F;
            4'h9: pat = 7'h6F;
            4'hA: pat = 7'h77;
            4'hB: pat = 7'h7C;
            4'hC: pat = 7'h39;
            4'hD: pat = 7'h5E;
            4'hE: pat = 7'h79;
            default: pat = 7'h71;
        endcase
    end

    always_comb begin
        an_d  = ~(4'b0001 << digit_q);
        seg_d = valid_q ? {1'b1, ~pat} : 8'b1011_1111;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            an_q  <= 4'hF;
            seg_q <= 8'hFF;
        end else begin
            an_q  <= an_d;
            seg_q <= seg_d;
        end
    end

    assign op_code = op_q;
    assign result  = res_q;
    assign valid   = valid_q;
    assign an      = an_q;
    assign seg     = seg_q;

endmodule
